// File: rtl/env_risk_pkg.sv
// Shared types and constants for the environmental risk monitor.
// State and zone encodings are deliberately identical so severities compare directly.
package env_risk_pkg;

  typedef enum logic [1:0] {
    ST_SAFE  = 2'd0,
    ST_WARN  = 2'd1,
    ST_ALARM = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ZN_SAFE  = 2'd0,
    ZN_WARN  = 2'd1,
    ZN_ALARM = 2'd2
  } zone_t;

  localparam logic [11:0] DEF_LO     = 12'h100;
  localparam logic [11:0] DEF_HI     = 12'hB00;
  localparam logic [11:0] DEF_MARGIN = 12'h080;

  localparam logic [15:0] W_ALARM = 16'h1000;
  localparam logic [15:0] W_WARN  = 16'h0100;

  function automatic state_t zone_to_state(input zone_t z);
    case (z)
      ZN_ALARM: return ST_ALARM;
      ZN_WARN:  return ST_WARN;
      default:  return ST_SAFE;
    endcase
  endfunction

endpackage

// File: rtl/env_zone_classifier.sv
// Combinational zone classifier: shifts lo/hi inward and widens the margin by
// offset, then places the sample in the ALARM, WARN or SAFE band.
module env_zone_classifier
  import env_risk_pkg::*;
#(
  parameter int DATA_W = 12
) (
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] margin,
  input  logic [DATA_W-1:0] offset,
  output zone_t             zone
);

  localparam int W = DATA_W + 1;

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W] ? {W{1'b1}} : s[W-1:0];
  endfunction

  function automatic logic [W-1:0] sat_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  logic [W-1:0] d_x, lo_a, hi_a, mg_a, lo_w, hi_w;

  always_comb begin
    d_x  = {1'b0, d};
    lo_a = sat_add({1'b0, lo}, {1'b0, offset});
    hi_a = sat_sub({1'b0, hi}, {1'b0, offset});
    mg_a = sat_add({1'b0, margin}, {1'b0, offset});
    lo_w = sat_add(lo_a, mg_a);
    hi_w = sat_sub(hi_a, mg_a);
    if (d_x < lo_a || d_x > hi_a)
      zone = ZN_ALARM;
    else if (d_x < lo_w || d_x > hi_w)
      zone = ZN_WARN;
    else
      zone = ZN_SAFE;
  end

endmodule

// File: rtl/env_risk_monitor.sv
// Multi-channel risk monitor: two-stage pipeline, per-channel persistence/hysteresis
// state tracking, aggregate score per processed sample.
module env_risk_monitor
  import env_risk_pkg::*;
#(
  parameter int                NUM_CH  = 4,
  parameter int                DATA_W  = 12,
  parameter int                CH_W    = $clog2(NUM_CH),
  parameter int                PERSIST = 3,
  parameter logic [DATA_W-1:0] HYST    = DATA_W'(12'h020)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DATA_W-1:0] cfg_lo,
  input  logic [DATA_W-1:0] cfg_hi,
  input  logic [DATA_W-1:0] cfg_margin,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [CH_W-1:0]   s_ch,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CH_W-1:0]   m_ch,
  output logic [1:0]        m_state,
  output logic [15:0]       m_score,
  output logic [NUM_CH-1:0] warn_mask,
  output logic [NUM_CH-1:0] alarm_mask
);

  localparam int CNT_W = $clog2(PERSIST + 1);

  logic              s1_v, s2_v;
  logic [CH_W-1:0]   s1_ch, s2_ch;
  logic [DATA_W-1:0] s1_d, s2_d;

  logic [DATA_W-1:0] lo_q [NUM_CH];
  logic [DATA_W-1:0] hi_q [NUM_CH];
  logic [DATA_W-1:0] mg_q [NUM_CH];
  state_t            st_q   [NUM_CH];
  state_t            st_nxt [NUM_CH];
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_nxt[NUM_CH];
  zone_t             tgt_q  [NUM_CH];
  zone_t             tgt_nxt[NUM_CH];

  logic              adv, proc, hit_cfg;
  logic [DATA_W-1:0] cur_lo, cur_hi, cur_mg;
  state_t            cur_st, upd_st, res_st;
  logic [CNT_W-1:0]  cur_cnt, upd_cnt;
  zone_t             cur_tgt, upd_tgt, run_tgt;
  zone_t             nz, dz;
  logic [1:0]        nz_v, dz_v, st_v, tgt_v;
  logic [NUM_CH-1:0] warn_nxt, alarm_nxt;
  logic [15:0]       n_warn, n_alarm, score_nxt;

  // The whole pipeline freezes while a result is waiting to be consumed.
  assign adv     = !m_valid | m_ready;
  assign s_ready = !rst & adv;
  assign proc    = adv & s2_v;
  assign hit_cfg = cfg_we & (cfg_ch == s2_ch);

  always_comb begin
    cur_lo  = DATA_W'(DEF_LO);
    cur_hi  = DATA_W'(DEF_HI);
    cur_mg  = DATA_W'(DEF_MARGIN);
    cur_st  = ST_SAFE;
    cur_cnt = '0;
    cur_tgt = ZN_SAFE;
    for (int i = 0; i < NUM_CH; i++) begin
      if (s2_ch == CH_W'(i)) begin
        cur_lo  = lo_q[i];
        cur_hi  = hi_q[i];
        cur_mg  = mg_q[i];
        cur_st  = st_q[i];
        cur_cnt = cnt_q[i];
        cur_tgt = tgt_q[i];
      end
    end
  end

  env_zone_classifier #(.DATA_W(DATA_W)) u_zone_norm (
    .d(s2_d), .lo(cur_lo), .hi(cur_hi), .margin(cur_mg), .offset('0), .zone(nz)
  );

  env_zone_classifier #(.DATA_W(DATA_W)) u_zone_hyst (
    .d(s2_d), .lo(cur_lo), .hi(cur_hi), .margin(cur_mg), .offset(HYST), .zone(dz)
  );

  // tgt tracks the least severe zone of the current escalation run, so a
  // mixed WARN/ALARM run escalates only to WARN.
  always_comb begin
    nz_v    = nz;
    dz_v    = dz;
    st_v    = cur_st;
    tgt_v   = cur_tgt;
    run_tgt = cur_tgt;
    upd_st  = cur_st;
    upd_cnt = '0;
    upd_tgt = cur_tgt;
    if (nz_v > st_v) begin
      run_tgt = (cur_cnt == '0 || nz_v < tgt_v) ? nz : cur_tgt;
      if (int'(cur_cnt) + 1 >= PERSIST) begin
        upd_st = zone_to_state(run_tgt);
      end else begin
        upd_cnt = cur_cnt + 1'b1;
        upd_tgt = run_tgt;
      end
    end else if (dz_v < st_v) begin
      upd_st = zone_to_state(dz);
    end
    res_st = hit_cfg ? ST_SAFE : upd_st;
  end

  always_comb begin
    warn_nxt  = '0;
    alarm_nxt = '0;
    n_warn    = '0;
    n_alarm   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      st_nxt[i]  = st_q[i];
      cnt_nxt[i] = cnt_q[i];
      tgt_nxt[i] = tgt_q[i];
      if (proc && s2_ch == CH_W'(i)) begin
        st_nxt[i]  = upd_st;
        cnt_nxt[i] = upd_cnt;
        tgt_nxt[i] = upd_tgt;
      end
      if (cfg_we && cfg_ch == CH_W'(i)) begin
        st_nxt[i]  = ST_SAFE;
        cnt_nxt[i] = '0;
        tgt_nxt[i] = ZN_SAFE;
      end
      warn_nxt[i]  = (st_nxt[i] == ST_WARN);
      alarm_nxt[i] = (st_nxt[i] == ST_ALARM);
      if (warn_nxt[i])  n_warn  = n_warn + 16'd1;
      if (alarm_nxt[i]) n_alarm = n_alarm + 16'd1;
    end
    score_nxt = W_ALARM * n_alarm + W_WARN * n_warn;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v       <= 1'b0;
      s2_v       <= 1'b0;
      s1_ch      <= '0;
      s2_ch      <= '0;
      s1_d       <= '0;
      s2_d       <= '0;
      m_valid    <= 1'b0;
      m_ch       <= '0;
      m_state    <= '0;
      m_score    <= '0;
      warn_mask  <= '0;
      alarm_mask <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        lo_q[i]  <= DATA_W'(DEF_LO);
        hi_q[i]  <= DATA_W'(DEF_HI);
        mg_q[i]  <= DATA_W'(DEF_MARGIN);
        st_q[i]  <= ST_SAFE;
        cnt_q[i] <= '0;
        tgt_q[i] <= ZN_SAFE;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= st_nxt[i];
        cnt_q[i] <= cnt_nxt[i];
        tgt_q[i] <= tgt_nxt[i];
        if (cfg_we && cfg_ch == CH_W'(i)) begin
          lo_q[i] <= cfg_lo;
          hi_q[i] <= cfg_hi;
          mg_q[i] <= cfg_margin;
        end
      end
      warn_mask  <= warn_nxt;
      alarm_mask <= alarm_nxt;
      if (adv) begin
        s1_v    <= s_valid;
        s1_ch   <= s_ch;
        s1_d    <= s_data;
        s2_v    <= s1_v;
        s2_ch   <= s1_ch;
        s2_d    <= s1_d;
        m_valid <= s2_v;
        if (s2_v) begin
          m_ch    <= s2_ch;
          m_state <= res_st;
          m_score <= score_nxt;
        end
      end
    end
  end

endmodule
